// File: rtl/chimp_board_engine.sv
// chimp_board_engine: places numbers 1..level on a GRID_W x GRID_H board, shows them,
// hides them and scores the player's ordered clicks.
// Ports: clk/iResetN (async active-low); iStart/iLevel begin a round;
// iRandValid/iRandNum supply placement candidates; iClickValid/iClickX/iClickY are player clicks;
// iRdX/iRdY -> oRdOccupied/oRdVisible/oRdNum is the zero-latency renderer read port;
// oState/oExpected/oDoneLoad/oCorrectPulse/oWin/oLose report progress and verdict.
module chimp_board_engine #(
  parameter int GRID_W       = 8,
  parameter int GRID_H       = 8,
  parameter int MAX_LEVEL    = 40,
  parameter int RAND_W       = 8,
  parameter int SHOW_TIMEOUT = 0,
  localparam int X_W = $clog2(GRID_W),
  localparam int Y_W = $clog2(GRID_H),
  localparam int N_W = $clog2(MAX_LEVEL + 1)
) (
  input  logic              clk,
  input  logic              iResetN,
  input  logic              iStart,
  input  logic [N_W-1:0]    iLevel,
  input  logic              iRandValid,
  input  logic [RAND_W-1:0] iRandNum,
  input  logic              iClickValid,
  input  logic [X_W-1:0]    iClickX,
  input  logic [Y_W-1:0]    iClickY,
  input  logic [X_W-1:0]    iRdX,
  input  logic [Y_W-1:0]    iRdY,
  output logic              oRdOccupied,
  output logic              oRdVisible,
  output logic [N_W-1:0]    oRdNum,
  output logic [2:0]        oState,
  output logic [N_W-1:0]    oExpected,
  output logic              oDoneLoad,
  output logic              oCorrectPulse,
  output logic              oWin,
  output logic              oLose
);
  localparam int T_W = SHOW_TIMEOUT > 0 ? $clog2(SHOW_TIMEOUT + 1) : 1;
  localparam logic [X_W:0] GW = (X_W + 1)'(GRID_W);
  localparam logic [Y_W:0] GH = (Y_W + 1)'(GRID_H);
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_LOAD  = 3'd2,
    S_SHOW  = 3'd3,
    S_PLAY  = 3'd4,
    S_WIN   = 3'd5,
    S_LOSE  = 3'd6
  } state_t;
  state_t r_state, w_next;
  logic [GRID_H-1:0][GRID_W-1:0] r_occ;
  logic [N_W-1:0] r_num [GRID_H][GRID_W];
  logic [N_W-1:0] r_lvl, r_cnt, r_exp;
  logic [T_W-1:0] r_tmo;
  logic r_pulse;
  logic [X_W-1:0] w_rx;
  logic [Y_W-1:0] w_ry;
  logic [N_W-1:0] w_lvl_in;
  logic w_load, w_live, w_click, w_hit, w_miss, w_expire, w_accept, w_rd_ok, w_unused_rand;
  assign w_rx = iRandNum[X_W-1:0];
  assign w_ry = iRandNum[X_W+Y_W-1:X_W];
  assign w_unused_rand = ^(iRandNum >> (X_W + Y_W));
  // a placement is taken only on an in-range free cell while numbers remain to be placed
  assign w_load = r_state == S_LOAD && iRandValid && r_cnt != r_lvl &&
                  {1'b0, w_rx} < GW && {1'b0, w_ry} < GH && !r_occ[w_ry][w_rx];
  assign w_live = r_state == S_SHOW || r_state == S_PLAY;
  // clicks on empty or off-board cells are ignored entirely
  assign w_click = iClickValid && w_live && {1'b0, iClickX} < GW && {1'b0, iClickY} < GH &&
                   r_occ[iClickY][iClickX];
  assign w_hit = w_click && r_num[iClickY][iClickX] == r_exp;
  assign w_miss = w_click && r_num[iClickY][iClickX] != r_exp;
  // the counter sits at 1 during the last visible cycle; it never reaches 1 when SHOW_TIMEOUT is 0
  assign w_expire = r_state == S_SHOW && r_tmo == T_W'(1);
  assign w_accept = iStart && (r_state == S_IDLE || r_state == S_WIN || r_state == S_LOSE);
  assign w_lvl_in = iLevel == '0 ? N_W'(1) : iLevel > N_W'(MAX_LEVEL) ? N_W'(MAX_LEVEL) : iLevel;
  assign w_rd_ok = {1'b0, iRdX} < GW && {1'b0, iRdY} < GH;
  always_ff @(posedge clk or negedge iResetN)
    if (!iResetN) r_state <= S_IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_WIN, S_LOSE: w_next = w_accept ? S_CLEAR : r_state;
      S_CLEAR: w_next = S_LOAD;
      S_LOAD: w_next = r_cnt == r_lvl ? S_SHOW : S_LOAD;
      S_SHOW, S_PLAY: w_next = w_miss ? S_LOSE : (w_hit && r_exp == r_lvl) ? S_WIN :
                               (w_hit || w_expire) ? S_PLAY : r_state;
      default: w_next = S_IDLE;
    endcase
  end
  always_comb begin
    oRdOccupied = w_rd_ok && r_occ[iRdY][iRdX];
    oRdVisible = oRdOccupied && (r_state == S_SHOW || r_state == S_LOSE);
    oRdNum = oRdVisible ? r_num[iRdY][iRdX] : '0;
    oState = r_state;
    oExpected = r_exp;
    oDoneLoad = w_live;
    oCorrectPulse = r_pulse;
    oWin = r_state == S_WIN;
    oLose = r_state == S_LOSE;
  end
  always_ff @(posedge clk or negedge iResetN)
    if (!iResetN) begin
      r_lvl <= '0;
      r_cnt <= '0;
      r_exp <= '0;
      r_tmo <= '0;
      r_pulse <= 1'b0;
    end else begin
      r_pulse <= w_hit;
      r_lvl <= w_accept ? w_lvl_in : r_lvl;
      r_cnt <= r_state == S_CLEAR ? '0 : w_load ? r_cnt + N_W'(1) : r_cnt;
      // the winning click leaves oExpected at lvl
      r_exp <= r_state == S_CLEAR ? N_W'(1) : (w_hit && r_exp != r_lvl) ? r_exp + N_W'(1) : r_exp;
      r_tmo <= (r_state == S_LOAD && r_cnt == r_lvl) ? T_W'(SHOW_TIMEOUT) :
               (r_state == S_SHOW && r_tmo != '0) ? r_tmo - T_W'(1) : r_tmo;
    end
  always_ff @(posedge clk or negedge iResetN)
    if (!iResetN) begin
      r_occ <= '0;
      r_num <= '{default: '0};
    end else if (r_state == S_CLEAR) begin
      r_occ <= '0;
      r_num <= '{default: '0};
    end else if (w_load) begin
      r_occ[w_ry][w_rx] <= 1'b1;
      r_num[w_ry][w_rx] <= r_cnt + N_W'(1);
    end else if (w_hit) begin
      r_occ[iClickY][iClickX] <= 1'b0;
      r_num[iClickY][iClickX] <= '0;
    end
endmodule

// File: tb/tb_chimp_board_engine.sv
// tb_chimp_board_engine: checks an 8x8 untimed board and a 5x8 board with a 10-cycle show timeout
`timescale 1ns/1ps
module tb_chimp_board_engine;
  logic clk = 1'b0;
  always #50 clk = ~clk;
  logic rn[2], st[2], rv[2], cv[2], pk_on[2];
  logic [5:0] lv[2];
  logic [7:0] rnd[2];
  logic [2:0] cx[2], cy[2], rdx[2], rdy[2], pk_x[2], pk_y[2];
  logic ro[2], rvis[2], dl[2], cp[2], ow[2], ol[2];
  logic [5:0] rnum[2], ex[2];
  logic [2:0] so[2];
  int scan[2];
  int n_chk = 0, n_err = 0;
  int ms[2], mlvl[2], mexp[2], mcnt[2], msh[2], mpulse[2];
  int mb[2][8][8];
  chimp_board_engine #(.GRID_W(8), .GRID_H(8), .MAX_LEVEL(40), .RAND_W(8), .SHOW_TIMEOUT(0)) u_a (
    .clk(clk), .iResetN(rn[0]), .iStart(st[0]), .iLevel(lv[0]), .iRandValid(rv[0]),
    .iRandNum(rnd[0]), .iClickValid(cv[0]), .iClickX(cx[0]), .iClickY(cy[0]),
    .iRdX(rdx[0]), .iRdY(rdy[0]), .oRdOccupied(ro[0]), .oRdVisible(rvis[0]), .oRdNum(rnum[0]),
    .oState(so[0]), .oExpected(ex[0]), .oDoneLoad(dl[0]), .oCorrectPulse(cp[0]),
    .oWin(ow[0]), .oLose(ol[0]));
  chimp_board_engine #(.GRID_W(5), .GRID_H(8), .MAX_LEVEL(40), .RAND_W(8), .SHOW_TIMEOUT(10)) u_b (
    .clk(clk), .iResetN(rn[1]), .iStart(st[1]), .iLevel(lv[1]), .iRandValid(rv[1]),
    .iRandNum(rnd[1]), .iClickValid(cv[1]), .iClickX(cx[1]), .iClickY(cy[1]),
    .iRdX(rdx[1]), .iRdY(rdy[1]), .oRdOccupied(ro[1]), .oRdVisible(rvis[1]), .oRdNum(rnum[1]),
    .oState(so[1]), .oExpected(ex[1]), .oDoneLoad(dl[1]), .oCorrectPulse(cp[1]),
    .oWin(ow[1]), .oLose(ol[1]));
  function automatic int gw(int k);
    return k == 0 ? 8 : 5;
  endfunction
  function automatic int tmo(int k);
    return k == 0 ? 0 : 10;
  endfunction
  task automatic chk(int k, string nm, int act, int want);
    n_chk++;
    if (act != want) begin
      n_err++;
      $display("FAIL dut%0d %s got %0d want %0d at %0t", k, nm, act, want, $time);
    end
  endtask
  always_comb
    for (int k = 0; k < 2; k++) begin
      rdx[k] = pk_on[k] ? pk_x[k] : 3'(scan[k]);
      rdy[k] = pk_on[k] ? pk_y[k] : 3'(scan[k] >> 3);
    end
  initial begin
    scan[0] = 0;
    scan[1] = 0;
    forever begin
      @(negedge clk);
      #2;
      for (int k = 0; k < 2; k++) scan[k] = (scan[k] + 7) % 64;
    end
  end
  task automatic mreset(int k);
    ms[k] = 0; mlvl[k] = 0; mexp[k] = 0; mcnt[k] = 0; msh[k] = 0; mpulse[k] = 0;
    for (int x = 0; x < 8; x++) for (int y = 0; y < 8; y++) mb[k][x][y] = 0;
  endtask
  task automatic mstep(int k);
    int ns, x, y;
    ns = ms[k];
    mpulse[k] = 0;
    if (ms[k] == 0 || ms[k] == 5 || ms[k] == 6) begin
      if (st[k]) begin
        mlvl[k] = int'(lv[k]) == 0 ? 1 : int'(lv[k]) > 40 ? 40 : int'(lv[k]);
        ns = 1;
      end
    end else if (ms[k] == 1) begin
      for (int i = 0; i < 64; i++) mb[k][i % 8][i / 8] = 0;
      mcnt[k] = 0;
      mexp[k] = 1;
      ns = 2;
    end else if (ms[k] == 2) begin
      if (mcnt[k] == mlvl[k]) begin
        ns = 3;
        msh[k] = 0;
      end else if (rv[k]) begin
        x = int'(rnd[k]) % 8;
        y = (int'(rnd[k]) / 8) % 8;
        if (x < gw(k) && mb[k][x][y] == 0) begin
          mcnt[k]++;
          mb[k][x][y] = mcnt[k];
        end
      end
    end else begin
      if (ms[k] == 3) begin
        msh[k]++;
        if (tmo(k) != 0 && msh[k] == tmo(k)) ns = 4;
      end
      x = int'(cx[k]);
      y = int'(cy[k]);
      if (cv[k] && x < gw(k) && mb[k][x][y] != 0) begin
        if (mb[k][x][y] == mexp[k]) begin
          mb[k][x][y] = 0;
          mpulse[k] = 1;
          if (mexp[k] == mlvl[k]) ns = 5;
          else begin
            mexp[k]++;
            ns = 4;
          end
        end else ns = 6;
      end
    end
    ms[k] = ns;
  endtask
  always @(posedge clk)
    for (int k = 0; k < 2; k++)
      if (!rn[k]) mreset(k);
      else mstep(k);
  always @(negedge clk)
    for (int k = 0; k < 2; k++)
      if (rn[k]) begin
        int x, y, occ, vis;
        x = int'(rdx[k]);
        y = int'(rdy[k]);
        occ = (x < gw(k) && mb[k][x][y] != 0) ? 1 : 0;
        vis = (occ == 1 && (ms[k] == 3 || ms[k] == 6)) ? 1 : 0;
        chk(k, "state", int'(so[k]), ms[k]);
        chk(k, "expected", int'(ex[k]), mexp[k]);
        chk(k, "doneload", int'(dl[k]), int'(ms[k] == 3 || ms[k] == 4));
        chk(k, "pulse", int'(cp[k]), mpulse[k]);
        chk(k, "win", int'(ow[k]), int'(ms[k] == 5));
        chk(k, "lose", int'(ol[k]), int'(ms[k] == 6));
        chk(k, "rd_occ", int'(ro[k]), occ);
        chk(k, "rd_vis", int'(rvis[k]), vis);
        chk(k, "rd_num", int'(rnum[k]), vis == 1 ? mb[k][x][y] : 0);
      end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic start(int k, int l);
    st[k] = 1'b1;
    lv[k] = 6'(l);
    cyc();
    st[k] = 1'b0;
  endtask
  task automatic push(int k, int v);
    rv[k] = 1'b1;
    rnd[k] = 8'(v);
    cyc();
    rv[k] = 1'b0;
  endtask
  task automatic click(int k, int x, int y);
    cv[k] = 1'b1;
    cx[k] = 3'(x);
    cy[k] = 3'(y);
    cyc();
    cv[k] = 1'b0;
  endtask
  task automatic peek(int k, int x, int y, int o, int v, int n, string nm);
    pk_on[k] = 1'b1;
    pk_x[k] = 3'(x);
    pk_y[k] = 3'(y);
    #1;
    chk(k, {nm, ".occ"}, int'(ro[k]), o);
    chk(k, {nm, ".vis"}, int'(rvis[k]), v);
    chk(k, {nm, ".num"}, int'(rnum[k]), n);
    pk_on[k] = 1'b0;
  endtask
  initial begin
    int n;
    for (int k = 0; k < 2; k++) begin
      rn[k] = 1'b0; st[k] = 1'b0; lv[k] = '0; rv[k] = 1'b0; rnd[k] = '0;
      cv[k] = 1'b0; cx[k] = '0; cy[k] = '0; pk_on[k] = 1'b0; pk_x[k] = '0; pk_y[k] = '0;
    end
    cyc();
    cyc();
    rn[0] = 1'b1;
    rn[1] = 1'b1;
    chk(0, "rst_state", int'(so[0]), 0);
    chk(0, "rst_expected", int'(ex[0]), 0);
    start(0, 4);
    chk(0, "clear_state", int'(so[0]), 1);
    cyc();
    chk(0, "load_state", int'(so[0]), 2);
    push(0, 'h00);
    push(0, 'h00);
    push(0, 'h09);
    push(0, 'h3F);
    push(0, 'h12);
    chk(0, "load_hold", int'(so[0]), 2);
    cyc();
    chk(0, "show_state", int'(so[0]), 3);
    chk(0, "show_expected", int'(ex[0]), 1);
    peek(0, 0, 0, 1, 1, 1, "c00");
    peek(0, 1, 1, 1, 1, 2, "c11");
    peek(0, 7, 7, 1, 1, 3, "c77");
    peek(0, 2, 2, 1, 1, 4, "c22");
    peek(0, 0, 1, 0, 0, 0, "c01");
    click(0, 0, 0);
    chk(0, "play_state", int'(so[0]), 4);
    chk(0, "hit1_pulse", int'(cp[0]), 1);
    chk(0, "hit1_expected", int'(ex[0]), 2);
    peek(0, 1, 1, 1, 0, 0, "hidden11");
    peek(0, 0, 0, 0, 0, 0, "cleared00");
    click(0, 1, 1);
    chk(0, "hit2_expected", int'(ex[0]), 3);
    click(0, 7, 7);
    click(0, 2, 2);
    chk(0, "win_flag", int'(ow[0]), 1);
    chk(0, "win_expected", int'(ex[0]), 4);
    start(0, 3);
    chk(0, "restart_state", int'(so[0]), 1);
    cyc();
    push(0, 'h05);
    push(0, 'h1B);
    push(0, 'h24);
    cyc();
    peek(0, 5, 0, 1, 1, 1, "r2c50");
    peek(0, 4, 4, 1, 1, 3, "r2c44");
    click(0, 5, 0);
    click(0, 0, 0);
    chk(0, "empty_state", int'(so[0]), 4);
    chk(0, "empty_expected", int'(ex[0]), 2);
    chk(0, "empty_pulse", int'(cp[0]), 0);
    click(0, 4, 4);
    chk(0, "lose_flag", int'(ol[0]), 1);
    peek(0, 3, 3, 1, 1, 2, "lose33");
    peek(0, 4, 4, 1, 1, 3, "lose44");
    peek(0, 5, 0, 0, 0, 0, "lose50");
    click(0, 3, 3);
    chk(0, "lose_hold", int'(so[0]), 6);
    start(0, 0);
    cyc();
    push(0, 'h3F);
    chk(0, "lvl0_load", int'(so[0]), 2);
    cyc();
    peek(0, 7, 7, 1, 1, 1, "lvl0_c77");
    click(0, 7, 7);
    chk(0, "lvl0_win", int'(ow[0]), 1);
    start(0, 50);
    cyc();
    for (int i = 0; i < 40; i++) push(0, i);
    chk(0, "lvl50_hold", int'(so[0]), 2);
    cyc();
    chk(0, "lvl50_show", int'(so[0]), 3);
    peek(0, 7, 4, 1, 1, 40, "lvl50_c74");
    click(0, 1, 0);
    chk(0, "lvl50_lose", int'(so[0]), 6);
    start(0, 5);
    cyc();
    push(0, 'h01);
    push(0, 'h02);
    cv[0] = 1'b1;
    cx[0] = 3'd1;
    cy[0] = 3'd0;
    push(0, 'h03);
    cv[0] = 1'b0;
    chk(0, "loadclick_state", int'(so[0]), 2);
    peek(0, 1, 0, 1, 0, 0, "load10");
    #10;
    rn[0] = 1'b0;
    #1;
    chk(0, "async_state", int'(so[0]), 0);
    chk(0, "async_expected", int'(ex[0]), 0);
    peek(0, 1, 0, 0, 0, 0, "async10");
    peek(0, 3, 0, 0, 0, 0, "async30");
    cyc();
    cyc();
    rn[0] = 1'b1;
    chk(0, "post_rst_state", int'(so[0]), 0);
    start(1, 2);
    cyc();
    push(1, 'h06);
    push(1, 'h04);
    peek(1, 4, 0, 1, 0, 0, "b_load40");
    push(1, 'h0C);
    n = 0;
    while (so[1] != 3'd3 && n < 5) begin
      cyc();
      n++;
    end
    chk(1, "show_latency", n, 1);
    peek(1, 4, 0, 1, 1, 1, "b40");
    peek(1, 4, 1, 1, 1, 2, "b41");
    peek(1, 6, 0, 0, 0, 0, "b_oob60");
    n = 0;
    while (so[1] != 3'd4 && n < 30) begin
      st[1] = n == 3;
      lv[1] = 6'd1;
      cyc();
      n++;
    end
    st[1] = 1'b0;
    chk(1, "timeout_cycles", n, 10);
    start(1, 2);
    chk(1, "play_start_ignored", int'(so[1]), 4);
    click(1, 4, 1);
    chk(1, "b_lose", int'(ol[1]), 1);
    peek(1, 4, 0, 1, 1, 1, "b_lose40");
    cyc();
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/chimp_board_engine.md
Name: chimp_board_engine

Overview:
- Parametrised chimp-test board engine: places numbers 1..level on free cells of a GRID_W x GRID_H board, shows them, then hides them and scores the player's ordered clicks.
- Sits between the chimp-test control FSM / LFSR and the VGA renderer.
- The renderer reads cells through a combinational read port; there is no full-board output bus.
- Adds over the previous generation: arbitrary grid size, retry-on-collision loading, an auto-hide timeout, clearing of cells as they are picked, and a win/lose verdict state.

Parameters:
- GRID_W, 8, board columns (2..16)
- GRID_H, 8, board rows (2..16)
- MAX_LEVEL, 40, highest supported level; must satisfy MAX_LEVEL <= GRID_W*GRID_H
- RAND_W, 8, width of the random input; must be >= X_W+Y_W
- SHOW_TIMEOUT, 0, cycles the numbers stay visible after load completes; 0 means visible until the first correct click
- Derived: X_W=$clog2(GRID_W), Y_W=$clog2(GRID_H), N_W=$clog2(MAX_LEVEL+1)

Ports:
- clk  in  1  system clock
- iResetN  in  1  asynchronous, active-low reset
- iStart  in  1  start-round pulse
- iLevel  in  N_W  number count for the round; latched on an accepted iStart
- iRandValid  in  1  iRandNum is fresh this cycle
- iRandNum  in  RAND_W  random cell candidate: [X_W-1:0]=x, [X_W+Y_W-1:X_W]=y
- iClickValid  in  1  one-cycle mouse click pulse
- iClickX  in  X_W  clicked column
- iClickY  in  Y_W  clicked row
- iRdX  in  X_W  renderer read column
- iRdY  in  Y_W  renderer read row
- oRdOccupied  out  1  cell at (iRdX,iRdY) holds a number
- oRdVisible  out  1  cell's number is currently drawn
- oRdNum  out  N_W  cell number when visible, else 0
- oState  out  3  0 IDLE, 1 CLEAR, 2 LOAD, 3 SHOW, 4 PLAY, 5 WIN, 6 LOSE
- oExpected  out  N_W  next number the player must click
- oDoneLoad  out  1  high in SHOW and PLAY
- oCorrectPulse  out  1  one-cycle pulse on each correct click
- oWin  out  1  level in WIN
- oLose  out  1  level in LOSE

Behaviour:
- Reset (async, iResetN=0): state IDLE, all cells cleared, oExpected=0, latched level=0, all flags and pulses 0, timeout counter 0.
- Per-cell storage: occupied bit plus N_W number.
- iStart is accepted only in IDLE, WIN and LOSE; it is ignored in CLEAR, LOAD, SHOW and PLAY.
- On an accepted iStart: latch lvl = clamp(iLevel, 1, MAX_LEVEL); go to CLEAR.
- CLEAR (1 cycle): zero every cell, load counter=0, oExpected=1; go to LOAD.
- LOAD: one placement attempt per cycle, and only when iRandValid=1.
  - If x>=GRID_W, y>=GRID_H or the cell is occupied, reject the attempt with no state change.
  - Otherwise write number count+1, set occupied, and increment count.
  - The cycle after count reaches lvl, go to SHOW; the timeout counter loads SHOW_TIMEOUT.
- SHOW: oRdVisible=oRdOccupied.
  - If SHOW_TIMEOUT!=0, decrement each cycle; at 0, go to PLAY.
  - Clicks are evaluated exactly as in PLAY. A correct click on 1 also moves to PLAY.
- PLAY: oRdVisible=0; occupied cells render as blank tiles.
- Click evaluation (SHOW/PLAY), judged on the registered cell contents:
  - Out-of-range coordinates or an unoccupied cell: ignored.
  - Number == oExpected: clear the cell, pulse oCorrectPulse next cycle, oExpected+1. If oExpected == lvl, go to WIN instead.
  - Number != oExpected: go to LOSE; the board is left intact so the renderer can reveal it.
- WIN: oRdVisible=0, oWin=1. LOSE: oRdVisible=oRdOccupied, oLose=1. Both hold until an accepted iStart or reset.
- Clicks are ignored in IDLE, CLEAR, LOAD, WIN and LOSE.
- When the timeout expiry and a click land in the same cycle, the click is evaluated and the state goes to PLAY, unless the click decides WIN or LOSE.
- Read port is purely combinational (zero latency); out-of-range read coordinates return all zeros.
- oExpected width is N_W; it never exceeds lvl, so there is no wrap.

Test Plan:
- Reset mid-LOAD (count=3): assert iResetN=0 -> state IDLE immediately (asynchronous); every read returns 0; oExpected=0.
- iLevel=4, iRandNum sequence 0x00, 0x00, 0x09, 0x3F, 0x12 (GRID 8x8) -> the duplicate 0x00 is rejected; cells (0,0)=1, (1,1)=2, (7,7)=3, (2,2)=4; SHOW is entered 1 cycle after the 5th attempt.
- GRID_W=5: iRandNum x=6 -> attempt rejected and count unchanged; then x=4 -> accepted.
- Level 3, SHOW_TIMEOUT=0: click 1 -> state PLAY, oRdVisible=0 everywhere, oCorrectPulse=1; click 2 -> oExpected 3; click 3 -> oWin=1, and iStart now restarts.
- Level 3: after 1 is cleared, click the cell holding 3 -> LOSE, oLose=1, cells 2 and 3 readable and visible; clicking an empty cell beforehand changes nothing.
- SHOW_TIMEOUT=10, level 2, no clicks -> PLAY exactly 10 cycles after SHOW entry; iStart during PLAY is ignored.
